// File: rtl/trajectory_capture.sv
// Trajectory capture: records the simulator's masked network state each time
// the round number changes and once more when steady state is reached.
// Records go into a first-word-fall-through FIFO for a downstream consumer.
module trajectory_capture #(
    parameter int STATE_W = 64,
    parameter int RN_W    = 10,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] network_state,
    input  logic [RN_W-1:0]    round_number,
    input  logic               steady_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic [RN_W-1:0]    out_round,
    output logic               out_last,
    output logic               run_done,
    output logic               overflow,
    output logic [7:0]         drop_cnt,
    output logic [15:0]        rounds_captured
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_r;
    logic [RN_W-1:0]   prev_round_r;
    logic              steady_q_r;
    logic              run_done_r;

    logic [STATE_W-1:0] mem_state_r [DEPTH];
    logic [RN_W-1:0]    mem_round_r [DEPTH];
    logic               mem_last_r  [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic               valid_r;
    logic               overflow_r;
    logic [7:0]         drop_cnt_r;
    logic [15:0]        rounds_r;

    logic               rise_s;
    logic               push_s;
    logic               push_last_s;
    logic               pop_s;
    logic               accept_s;
    logic               drop_s;
    logic [CW-1:0]      count_next_s;

    // Decide whether this cycle produces a record and whether it is the steady-state one.
    always_comb begin
        push_s      = 1'b0;
        push_last_s = 1'b0;
        rise_s      = steady_state & ~steady_q_r;
        if (start) begin
            push_s      = 1'b0;
            push_last_s = 1'b0;
        end else begin
            case (state_r)
                ARMED: begin
                    push_s = 1'b1;
                end
                CAPTURE: begin
                    if (rise_s) begin
                        push_s      = 1'b1;
                        push_last_s = 1'b1;
                    end else if (round_number != prev_round_r) begin
                        push_s = 1'b1;
                    end else begin
                        push_s = 1'b0;
                    end
                end
                default: begin
                    push_s      = 1'b0;
                    push_last_s = 1'b0;
                end
            endcase
        end
    end

    // FIFO handshake: a full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        pop_s        = valid_r & out_ready;
        accept_s     = push_s & ((count_r < CW'(DEPTH)) | pop_s);
        drop_s       = push_s & ~accept_s;
        count_next_s = count_r;
        if (start) begin
            count_next_s = {CW{1'b0}};
        end else if (accept_s && !pop_s) begin
            count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end else if (!accept_s && pop_s) begin
            count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_next_s = count_r;
        end
    end

    // Run sequencing: arm on start, capture round changes, drain, then report done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            prev_round_r <= {RN_W{1'b0}};
            steady_q_r   <= 1'b0;
            run_done_r   <= 1'b0;
        end else begin
            steady_q_r <= steady_state;
            if (start) begin
                state_r    <= ARMED;
                run_done_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    ARMED: begin
                        prev_round_r <= round_number;
                        state_r      <= CAPTURE;
                    end
                    CAPTURE: begin
                        prev_round_r <= round_number;
                        if (rise_s) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= CAPTURE;
                        end
                    end
                    DRAIN: begin
                        if (count_r == {CW{1'b0}}) begin
                            state_r    <= DONE;
                            run_done_r <= 1'b1;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end
                    DONE: begin
                        state_r <= DONE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO storage, pointers and per-run statistics; start wipes everything for a fresh run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_state_r[i] <= {STATE_W{1'b0}};
                mem_round_r[i] <= {RN_W{1'b0}};
                mem_last_r[i]  <= 1'b0;
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
            rounds_r   <= 16'd0;
        end else if (start) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
            rounds_r   <= 16'd0;
        end else begin
            if (accept_s) begin
                mem_state_r[wr_ptr_r] <= network_state;
                mem_round_r[wr_ptr_r] <= round_number;
                mem_last_r[wr_ptr_r]  <= push_last_s;
                wr_ptr_r              <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                if (rounds_r != 16'hFFFF) begin
                    rounds_r <= rounds_r + 16'd1;
                end else begin
                    rounds_r <= rounds_r;
                end
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 8'hFF) begin
                    drop_cnt_r <= drop_cnt_r + 8'd1;
                end else begin
                    drop_cnt_r <= drop_cnt_r;
                end
            end else begin
                overflow_r <= overflow_r;
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != {CW{1'b0}});
        end
    end

    assign out_valid       = valid_r;
    assign out_state       = mem_state_r[rd_ptr_r];
    assign out_round       = mem_round_r[rd_ptr_r];
    assign out_last        = valid_r & mem_last_r[rd_ptr_r];
    assign run_done        = run_done_r;
    assign overflow        = overflow_r;
    assign drop_cnt        = drop_cnt_r;
    assign rounds_captured = rounds_r;

endmodule
